// File: rtl/naive_bus_pkg.sv
// -----------------------------------------------------------------------------
// naive_bus_pkg
// Shared definitions for naive_bus masters:
//   copy_state_t - state encoding of the block-copy engine
//   BE_WORD      - byte enable for a full 32-bit word access
//   WORD_BYTES   - address stride between consecutive words
//   word_align() - clears the byte-offset bits of a byte address
// -----------------------------------------------------------------------------
package naive_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    FIN
  } copy_state_t;

  localparam logic [3:0]  BE_WORD    = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Byte addresses are word-aligned by dropping bits [1:0].
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/naive_bus.sv
// -----------------------------------------------------------------------------
// naive_bus
// Single-master view of the naive_bus read and write channels.
//   rd_req/rd_gnt/rd_be/rd_addr : read request channel (master -> slave)
//   rd_data                     : read data, valid the cycle after rd handshake
//   wr_req/wr_gnt/wr_be/wr_addr/wr_data : write channel, completes on handshake
// -----------------------------------------------------------------------------
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_be, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );
endinterface

// File: rtl/naive_bus_copy_master.sv
// -----------------------------------------------------------------------------
// naive_bus_copy_master
// Bus master that copies word_cnt 32-bit words from src_addr to dst_addr,
// one read followed by one write per word (forward order, no overlap checks).
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   start           - 1-cycle pulse, latches src_addr/dst_addr/word_cnt when idle
//   src_addr        - source byte address (bits [1:0] ignored)
//   dst_addr        - destination byte address (bits [1:0] ignored)
//   word_cnt        - number of words to copy (0 = finish without bus traffic)
//   abort           - finish after the word currently in flight
//   busy            - copy in progress
//   done            - 1-cycle completion pulse
//   aborted         - qualifies done: copy was cut short by abort
//   bus             - naive_bus master port
// -----------------------------------------------------------------------------
module naive_bus_copy_master
  import naive_bus_pkg::*;
#(
  parameter int MAX_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [MAX_LEN_W-1:0] word_cnt,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  naive_bus.master             bus
);

  localparam logic [MAX_LEN_W-1:0] CNT_ONE  = {{(MAX_LEN_W-1){1'b0}}, 1'b1};
  localparam logic [MAX_LEN_W-1:0] CNT_ZERO = '0;

  copy_state_t          state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 aborted_q;
  logic                 abort_pend_q;
  logic                 rd_req_q;
  logic                 wr_req_q;
  logic [31:0]          src_q;
  logic [31:0]          dst_q;
  logic [31:0]          data_q;
  logic [MAX_LEN_W-1:0] rem_q;

  // The address registers double as the bus addresses; they only move after
  // a write handshake, so they are stable while a request waits for grant.
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = src_q;
  assign bus.rd_be   = rd_req_q ? BE_WORD : 4'h0;
  assign bus.wr_req  = wr_req_q;
  assign bus.wr_addr = dst_q;
  assign bus.wr_data = data_q;
  assign bus.wr_be   = wr_req_q ? BE_WORD : 4'h0;

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
      rem_q        <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;

      // Abort is only remembered while a copy is actually running.
      if (abort && (state_q != IDLE) && (state_q != FIN)) begin
        abort_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            src_q <= word_align(src_addr);
            dst_q <= word_align(dst_addr);
            rem_q <= word_cnt;
            if (word_cnt != CNT_ZERO) begin
              busy_q   <= 1'b1;
              rd_req_q <= 1'b1;
              state_q  <= RD_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end

        RD_REQ: begin
          if (bus.rd_gnt) begin
            rd_req_q <= 1'b0;
            state_q  <= RD_DATA;
          end
        end

        RD_DATA: begin
          data_q   <= bus.rd_data;
          wr_req_q <= 1'b1;
          state_q  <= WR_REQ;
        end

        WR_REQ: begin
          if (bus.wr_gnt) begin
            wr_req_q <= 1'b0;
            src_q    <= src_q + WORD_BYTES;
            dst_q    <= dst_q + WORD_BYTES;
            rem_q    <= rem_q - CNT_ONE;
            // An abort arriving with this grant still counts: no further read.
            if ((rem_q == CNT_ONE) || abort_pend_q || abort) begin
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              aborted_q <= abort_pend_q | abort;
              state_q   <= FIN;
            end else begin
              rd_req_q <= 1'b1;
              state_q  <= RD_REQ;
            end
          end
        end

        FIN: begin
          abort_pend_q <= 1'b0;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_naive_bus_copy_master.sv
// -----------------------------------------------------------------------------
// tb_naive_bus_copy_master
// Directed bench for naive_bus_copy_master: a vector table of copy jobs with
// hand-computed write counts, completion cycles and abort flags, a bus slave
// model with optional random grant delays, and hand-written sequences for
// reset behaviour.
// -----------------------------------------------------------------------------
module tb_naive_bus_copy_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_cnt;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;

  naive_bus bus_if ();

  naive_bus_copy_master #(.MAX_LEN_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .word_cnt (word_cnt),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .bus      (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ROM contents seen by the slave: low half is the word index.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  // ---------------- slave model and bus monitor ----------------
  bit            rnd_mode = 1'b0;
  int            rd_dly = 0;
  int            wr_dly = 0;
  bit            rd_pend = 1'b0;
  bit            wr_pend = 1'b0;
  logic [31:0]   rd_pend_addr = '0;
  logic [31:0]   wr_pend_addr = '0;
  bit            data_due = 1'b0;
  logic [31:0]   data_addr = '0;
  int            req_cycles = 0;
  logic [31:0]   rd_log[$];
  logic [63:0]   wr_log[$];

  assign bus_if.rd_gnt = bus_if.rd_req & (rd_dly == 0);
  assign bus_if.wr_gnt = bus_if.wr_req & (wr_dly == 0);

  initial bus_if.rd_data = 32'hDEAD_BEEF;

  always @(negedge clk) begin
    bit rd_hs;
    bit wr_hs;
    // Read data is driven only for the cycle right after the read handshake.
    bus_if.rd_data = data_due ? rom_word(data_addr) : 32'hDEAD_BEEF;
    data_due = 1'b0;

    if (!bus_if.rd_req) rd_dly = rnd_mode ? int'($urandom_range(0, 5)) : 0;
    else if (rd_dly != 0) rd_dly--;
    if (!bus_if.wr_req) wr_dly = rnd_mode ? int'($urandom_range(0, 5)) : 0;
    else if (wr_dly != 0) wr_dly--;

    if (rst_n) begin
      chk("rd_be", {60'd0, bus_if.rd_be}, bus_if.rd_req ? 64'hF : 64'h0);
      chk("wr_be", {60'd0, bus_if.wr_be}, bus_if.wr_req ? 64'hF : 64'h0);
      if (rd_pend) chk("rd_hold", {31'd0, bus_if.rd_req, bus_if.rd_addr}, {32'd1, rd_pend_addr});
      if (wr_pend) chk("wr_hold", {31'd0, bus_if.wr_req, bus_if.wr_addr}, {32'd1, wr_pend_addr});
      if (bus_if.rd_req || bus_if.wr_req) req_cycles++;

      rd_hs = bus_if.rd_req && (rd_dly == 0);
      wr_hs = bus_if.wr_req && (wr_dly == 0);
      if (rd_hs) begin
        rd_log.push_back(bus_if.rd_addr);
        data_due  = 1'b1;
        data_addr = bus_if.rd_addr;
      end
      if (wr_hs) wr_log.push_back({bus_if.wr_addr, bus_if.wr_data});
      rd_pend      = bus_if.rd_req && !rd_hs;
      wr_pend      = bus_if.wr_req && !wr_hs;
      rd_pend_addr = bus_if.rd_addr;
      wr_pend_addr = bus_if.wr_addr;
    end else begin
      rd_pend = 1'b0;
      wr_pend = 1'b0;
    end
  end

  // ---------------- vector table ----------------
  // abort_at / restart_at: cycle j (after the j-th edge past the start edge)
  // during which abort / a second start is driven; -1 = never.
  // exp_done: edge index at which done is sampled high; 0 = not checked.
  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] cnt;
    bit          rnd;
    int          abort_at;
    int          restart_at;
    int          exp_writes;
    bit          exp_aborted;
    int          exp_done;
  } vec_t;

  vec_t tbl[7];

  task automatic run_vec(input vec_t v);
    int  j;
    bit  seen;
    logic [31:0] s;
    logic [31:0] d;
    rnd_mode = v.rnd;
    rd_log.delete();
    wr_log.delete();
    req_cycles = 0;
    @(negedge clk);
    start = 1'b1; src_addr = v.src; dst_addr = v.dst; word_cnt = v.cnt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({v.name, ":busy_after_start"}, {63'd0, busy}, (v.cnt != 0) ? 64'd1 : 64'd0);
    seen = 1'b0;
    for (j = 0; j < 400; j++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      abort = (j == v.abort_at);
      if (j == v.restart_at) begin
        start = 1'b1; src_addr = 32'h0000_4000; dst_addr = 32'h0000_5000; word_cnt = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    chk({v.name, ":done_seen"}, {63'd0, seen}, 64'd1);
    if (v.exp_done != 0) chk({v.name, ":done_cycle"}, j + 1, v.exp_done);
    chk({v.name, ":aborted"}, {63'd0, aborted}, {63'd0, v.exp_aborted});
    chk({v.name, ":busy_at_done"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk({v.name, ":done_pulse_width"}, {63'd0, done}, 64'd0);
    @(negedge clk);
    chk({v.name, ":idle_busy"}, {63'd0, busy}, 64'd0);
    if (v.cnt == 0) chk({v.name, ":no_bus_traffic"}, req_cycles, 0);
    chk({v.name, ":write_count"}, wr_log.size(), v.exp_writes);
    chk({v.name, ":read_count"}, rd_log.size(), v.exp_writes);
    s = v.src & 32'hFFFF_FFFC;
    d = v.dst & 32'hFFFF_FFFC;
    for (int i = 0; i < v.exp_writes && i < wr_log.size() && i < rd_log.size(); i++) begin
      chk({v.name, ":rd_addr"}, {32'd0, rd_log[i]}, {32'd0, s});
      chk({v.name, ":write"}, wr_log[i], {d, rom_word(s)});
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name       src            dst            cnt  rnd ab  rs  wr ab  done
    tbl[0] = '{"basic4",   32'h0000_0000, 32'h0002_0000, 16'd4,  1'b0, -1, -1, 4, 1'b0, 13};
    tbl[1] = '{"rnd4",     32'h0000_0000, 32'h0002_0000, 16'd4,  1'b1, -1, -1, 4, 1'b0, 0};
    tbl[2] = '{"cnt0",     32'h0000_0040, 32'h0002_0000, 16'd0,  1'b0, -1, -1, 0, 1'b0, 1};
    tbl[3] = '{"abort3",   32'h0000_1000, 32'h0002_0100, 16'd10, 1'b0,  6, -1, 3, 1'b1, 10};
    tbl[4] = '{"wrap3",    32'hFFFF_FFF8, 32'h0000_0103, 16'd3,  1'b0, -1, -1, 3, 1'b0, 10};
    tbl[5] = '{"abortlast",32'h0000_0200, 32'h0000_0300, 16'd2,  1'b0,  5, -1, 2, 1'b1, 7};
    tbl[6] = '{"restart",  32'h0000_0100, 32'h0000_0200, 16'd2,  1'b0, -1,  2, 2, 1'b0, 7};

    start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; word_cnt = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", {55'd0, busy, done, aborted, bus_if.rd_req, bus_if.wr_req, bus_if.rd_be, bus_if.wr_be}, 64'd0);
    chk("reset_addr", {bus_if.rd_addr, bus_if.wr_addr}, 64'd0);
    chk("reset_wdata", {32'd0, bus_if.wr_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Abort while idle must not leak into the next copy.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_busy", {63'd0, busy}, 64'd0);

    for (int t = 0; t < 7; t++) run_vec(tbl[t]);

    // Reset asserted while word 2 waits in WR_REQ.
    rnd_mode = 1'b0;
    rd_log.delete();
    wr_log.delete();
    @(negedge clk);
    start = 1'b1; src_addr = 32'h0; dst_addr = 32'h0002_0000; word_cnt = 16'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid:in_wr_req", {62'd0, bus_if.wr_req, busy}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid:ctrl", {55'd0, busy, done, aborted, bus_if.rd_req, bus_if.wr_req, bus_if.rd_be, bus_if.wr_be}, 64'd0);
    chk("rst_mid:addr", {bus_if.rd_addr, bus_if.wr_addr}, 64'd0);
    chk("rst_mid:wdata", {32'd0, bus_if.wr_data}, 64'd0);
    chk("rst_mid:writes_before", wr_log.size(), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid:no_done", {62'd0, done, busy}, 64'd0);
    end

    run_vec(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
